// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction fetch sequencer with a 2-entry buffer and branch redirect.
// Define FETCH_HALT_DETECT_EN to stop fetching when an opcode 4'hF instruction is captured.
module fetch_ctrl #(
  parameter int ADDR_W = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = 16'h0000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  output logic [ADDR_W-1:0] inst_addr,
  input  logic [15:0]       inst,
  input  logic              br_valid,
  input  logic [ADDR_W-1:0] br_target,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [15:0]       out_inst,
  output logic [ADDR_W-1:0] out_pc,
  output logic              halted
);
  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;
  state_t state, state_n;
  logic [ADDR_W-1:0] pc, pc0, pc1;
  logic [15:0] i0, i1;
  logic [1:0] count, count_ap;
  logic in_flight, push, pop, issue, halt_cap;
  assign out_valid = count != 2'd0;
  assign out_inst = i0;
  assign out_pc = pc0;
  assign pop = out_valid & out_ready & ~br_valid;
  assign push = in_flight & ~br_valid;
  assign count_ap = count - {1'b0, pop};
`ifdef FETCH_HALT_DETECT_EN
  assign halt_cap = push & (inst[15:12] == 4'hF);
`else
  assign halt_cap = 1'b0;
`endif
  // Occupancy counts the slot freed by this cycle's pop so a full stream sustains one fetch per cycle.
  assign issue = en & (state != HALT) & ~br_valid & ~halt_cap & ((count_ap + {1'b0, in_flight}) < 2'd2);
  always_comb
    state_n = (br_valid && state == HALT) ? RUN :
              halt_cap                     ? HALT :
              (state == HALT)              ? HALT :
              en                           ? RUN : IDLE;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      halted <= 1'b0;
      pc <= RESET_PC;
      inst_addr <= RESET_PC;
      in_flight <= 1'b0;
      count <= 2'd0;
      i0 <= '0;
      i1 <= '0;
      pc0 <= '0;
      pc1 <= '0;
    end else begin
      state <= state_n;
      halted <= state_n == HALT;
      in_flight <= issue;
      if (br_valid) pc <= br_target;
      else if (issue) pc <= pc + {{(ADDR_W-1){1'b0}}, 1'b1};
      if (issue) inst_addr <= pc;
      count <= br_valid ? 2'd0 : count_ap + {1'b0, push};
      if (pop) begin
        i0 <= i1;
        pc0 <= pc1;
      end
      if (push && count_ap == 2'd0) begin
        i0 <= inst;
        pc0 <= inst_addr;
      end else if (push) begin
        i1 <= inst;
        pc1 <= inst_addr;
      end
    end
  assert property (@(posedge clk) disable iff (!rst_n) push |-> count != 2'd2);
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed scenarios plus a randomized run against an address-stream model.
module tb_fetch_ctrl;
  logic clk = 1'b0, rst_n = 1'b0, en = 1'b0, br_valid = 1'b0, out_ready = 1'b0, halt_mode = 1'b0;
  logic [15:0] br_target = '0, inst, inst_w, inst_addr, w_inst_addr, out_inst, w_out_inst, out_pc, w_out_pc;
  logic out_valid, w_out_valid, halted, w_halted;
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  assign inst = (halt_mode && inst_addr == 16'd3) ? 16'hF000 : {4'h1, inst_addr[11:0] ^ 12'hA5A};
  assign inst_w = (halt_mode && w_inst_addr == 16'd3) ? 16'hF000 : {4'h1, w_inst_addr[11:0] ^ 12'hA5A};

  function automatic logic [15:0] mw(input logic [15:0] a);
    return (halt_mode && a == 16'd3) ? 16'hF000 : {4'h1, a[11:0] ^ 12'hA5A};
  endfunction

  fetch_ctrl #(.ADDR_W(16), .RESET_PC(16'h0000)) u_dut (
    .clk(clk), .rst_n(rst_n), .en(en), .inst_addr(inst_addr), .inst(inst),
    .br_valid(br_valid), .br_target(br_target), .out_valid(out_valid), .out_ready(out_ready),
    .out_inst(out_inst), .out_pc(out_pc), .halted(halted));

  fetch_ctrl #(.ADDR_W(16), .RESET_PC(16'hFFFE)) u_wrap (
    .clk(clk), .rst_n(rst_n), .en(en), .inst_addr(w_inst_addr), .inst(inst_w),
    .br_valid(br_valid), .br_target(br_target), .out_valid(w_out_valid), .out_ready(out_ready),
    .out_inst(w_out_inst), .out_pc(w_out_pc), .halted(w_halted));

  task automatic test_reset;
    rst_n = 1'b0; en = 1'b0; out_ready = 1'b0; br_valid = 1'b0; halt_mode = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (inst_addr !== 16'h0000) begin bad++; $display("FAIL reset_inst_addr got=%h exp=0000", inst_addr); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    total++; if (out_inst !== 16'h0000) begin bad++; $display("FAIL reset_out_inst got=%h exp=0000", out_inst); end
    total++; if (out_pc !== 16'h0000) begin bad++; $display("FAIL reset_out_pc got=%h exp=0000", out_pc); end
    total++; if (halted !== 1'b0) begin bad++; $display("FAIL reset_halted got=%b exp=0", halted); end
    total++; if (w_inst_addr !== 16'hFFFE) begin bad++; $display("FAIL reset_wrap_inst_addr got=%h exp=fffe", w_inst_addr); end
  endtask

  task automatic test_stream;
    logic [15:0] e;
    rst_n = 1'b1; en = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL stream_startup got=%b exp=0", out_valid); end
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      e = 16'(k);
      total++; if (out_valid !== 1'b1 || out_pc !== e || out_inst !== mw(e))
        begin bad++; $display("FAIL stream_k%0d got=%b/%h/%h exp=1/%h/%h", k, out_valid, out_pc, out_inst, e, mw(e)); end
      e = 16'hFFFE + 16'(k);
      total++; if (w_out_valid !== 1'b1 || w_out_pc !== e || w_out_inst !== mw(e))
        begin bad++; $display("FAIL wrap_k%0d got=%b/%h/%h exp=1/%h/%h", k, w_out_valid, w_out_pc, w_out_inst, e, mw(e)); end
    end
  endtask

  task automatic test_stall;
    out_ready = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      total++; if (inst_addr !== 16'd8 || out_valid !== 1'b1 || out_pc !== 16'd7)
        begin bad++; $display("FAIL stall_c%0d got=%h/%b/%h exp=0008/1/0007", k, inst_addr, out_valid, out_pc); end
    end
    en = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    total++; if (out_valid !== 1'b1 || out_pc !== 16'd8) begin bad++; $display("FAIL stall_drain1 got=%b/%h exp=1/0008", out_valid, out_pc); end
    @(negedge clk);
    total++; if (out_valid !== 1'b0 || inst_addr !== 16'd8) begin bad++; $display("FAIL stall_drain2 got=%b/%h exp=0/0008", out_valid, inst_addr); end
  endtask

  task automatic test_branch;
    logic [15:0] t;
    en = 1'b1; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (out_valid !== 1'b1 || out_pc !== 16'd9) begin bad++; $display("FAIL branch_prefill got=%b/%h exp=1/0009", out_valid, out_pc); end
    for (int r = 0; r < 2; r++) begin
      t = (r == 0) ? 16'h0040 : 16'h0080;
      br_valid = 1'b1; br_target = t;
      @(negedge clk);
      br_valid = 1'b0; br_target = 16'h1234;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL branch%0d_flush got=%b exp=0", r, out_valid); end
      @(negedge clk);
      total++; if (out_valid !== 1'b0 || inst_addr !== t) begin bad++; $display("FAIL branch%0d_issue got=%b/%h exp=0/%h", r, out_valid, inst_addr, t); end
      @(negedge clk);
      total++; if (out_valid !== 1'b1 || out_pc !== t || out_inst !== mw(t))
        begin bad++; $display("FAIL branch%0d_first got=%b/%h/%h exp=1/%h/%h", r, out_valid, out_pc, out_inst, t, mw(t)); end
      out_ready = 1'b1;
      for (int k = 1; k < 4; k++) begin
        @(negedge clk);
        total++; if (out_valid !== 1'b1 || out_pc !== t + 16'(k))
          begin bad++; $display("FAIL branch%0d_k%0d got=%b/%h exp=1/%h", r, k, out_valid, out_pc, t + 16'(k)); end
      end
    end
  endtask

  task automatic test_halt;
    rst_n = 1'b0; halt_mode = 1'b1;
    @(negedge clk);
    rst_n = 1'b1; en = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      total++; if (out_valid !== 1'b1 || out_pc !== 16'(k) || out_inst !== mw(16'(k)))
        begin bad++; $display("FAIL halt_k%0d got=%b/%h/%h exp=1/%h/%h", k, out_valid, out_pc, out_inst, 16'(k), mw(16'(k))); end
    end
`ifdef FETCH_HALT_DETECT_EN
    total++; if (halted !== 1'b1) begin bad++; $display("FAIL halt_flag got=%b exp=1", halted); end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      total++; if (halted !== 1'b1 || out_valid !== 1'b0 || inst_addr !== 16'd3)
        begin bad++; $display("FAIL halt_hold%0d got=%b/%b/%h exp=1/0/0003", k, halted, out_valid, inst_addr); end
    end
    br_valid = 1'b1; br_target = 16'h0010;
    @(negedge clk);
    br_valid = 1'b0;
    total++; if (halted !== 1'b0) begin bad++; $display("FAIL halt_release got=%b exp=0", halted); end
    repeat (2) @(negedge clk);
    total++; if (out_valid !== 1'b1 || out_pc !== 16'h0010) begin bad++; $display("FAIL halt_resume got=%b/%h exp=1/0010", out_valid, out_pc); end
`else
    @(negedge clk);
    total++; if (halted !== 1'b0 || out_valid !== 1'b1 || out_pc !== 16'd4)
      begin bad++; $display("FAIL nohalt_continue got=%b/%b/%h exp=0/1/0004", halted, out_valid, out_pc); end
`endif
    halt_mode = 1'b0;
  endtask

  task automatic test_async;
    en = 1'b1; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0 || inst_addr !== 16'h0000 || out_pc !== 16'h0000 || out_inst !== 16'h0000 || halted !== 1'b0)
      begin bad++; $display("FAIL async_reset got=%b/%h/%h/%h/%b exp=0/0000/0000/0000/0", out_valid, inst_addr, out_pc, out_inst, halted); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL async_startup got=%b exp=0", out_valid); end
    @(negedge clk);
    total++; if (out_valid !== 1'b1 || out_pc !== 16'h0000) begin bad++; $display("FAIL async_restart got=%b/%h exp=1/0000", out_valid, out_pc); end
  endtask

  task automatic test_random;
    logic [15:0] exp_pc = 16'h0000;
    logic prev_br = 1'b0;
    int n_acc = 0;
    rst_n = 1'b0; en = 1'b0; out_ready = 1'b0; br_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 600; c++) begin
      en = $urandom_range(0, 9) < 8;
      out_ready = $urandom_range(0, 9) < 7;
      br_valid = $urandom_range(0, 19) == 0;
      br_target = 16'($urandom);
      if (prev_br) begin
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rand_flush c=%0d got=%b exp=0", c, out_valid); end
      end
      if (out_valid && out_ready && !br_valid) begin
        total++; if (out_pc !== exp_pc || out_inst !== mw(exp_pc))
          begin bad++; $display("FAIL rand_accept c=%0d got=%h/%h exp=%h/%h", c, out_pc, out_inst, exp_pc, mw(exp_pc)); end
        exp_pc = exp_pc + 16'd1;
        n_acc++;
      end
      if (br_valid) exp_pc = br_target;
      prev_br = br_valid;
      @(negedge clk);
    end
    br_valid = 1'b0;
    total++; if (n_acc < 100) begin bad++; $display("FAIL rand_progress got=%0d exp>=100", n_acc); end
  endtask

  initial begin
    test_reset;
    test_stream;
    test_stall;
    test_branch;
    test_halt;
    test_async;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
